spi_xfer_queue: RTL and testbench

- Upstream feeder for the SPI master byte engine, in the SPI clock domain.
- Buffers outgoing bytes in a small FIFO and presents them one at a time on the master's tx_data/tx_valid handshake.
- Waits for each full-duplex byte to complete, then captures the returned byte into a valid/ready output register for the consumer.
- Replaces the fixed constant tx_data / tied-high tx_valid stimulus used during bring-up.

---
 rtl/spi_xfer_queue_pkg.sv | 22 ++
 rtl/spi_xfer_queue_if.sv | 26 ++
 rtl/spi_sync_fifo.sv | 54 +++++
 rtl/spi_xfer_queue.sv | 122 ++++++++++++
 tb/tb_spi_xfer_queue.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_xfer_queue_pkg.sv
// rtl/spi_xfer_queue_pkg.sv - shared types, defaults and helpers for the SPI transfer queue
package spi_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_RX = 2'd2
    } xfer_state_t;

    // Address width for a FIFO of the given depth (depth is a power of two).
    function automatic int clog2_depth(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_xfer_queue_if.sv
// rtl/spi_xfer_queue_if.sv - byte handshake between the transfer queue and the SPI master engine
interface spi_xfer_queue_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_done;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    // Queue side: presents bytes, observes completion and received data.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_done,
        input  rx_data,
        input  rx_valid
    );

    // Byte engine side.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_done,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - single-clock first-word-fall-through FIFO for outgoing bytes
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_W-1:0]           din,
    output logic [DATA_W-1:0]           dout,
    output logic                        full,
    output logic                        empty,
    output logic [clog2_depth(DEPTH):0] level
);
    localparam int AW = clog2_depth(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == DEPTH[AW:0]);
    assign empty = (count == '0);
    assign level = count;
    assign dout  = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks +push -pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/spi_xfer_queue.sv
// rtl/spi_xfer_queue.sv - queues TX bytes to the SPI master and registers each returned byte
module spi_xfer_queue
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        wr_en,
    output logic                        full,
    output logic [clog2_depth(DEPTH):0] level,
    output logic                        overflow,
    output logic                        busy,
    spi_xfer_queue_if.master            spi,
    output logic [DATA_W-1:0]           rx_out_data,
    output logic                        rx_out_valid,
    input  logic                        rx_out_ready
);
    xfer_state_t       state_q, state_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              capture;
    logic              slot_free;

    spi_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (wr_en),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .level (level)
    );

    // A new transfer may only start once the previous received byte is gone or leaving now.
    assign slot_free    = !rx_out_valid || rx_out_ready;
    assign spi.tx_data  = tx_data_q;
    assign spi.tx_valid = tx_valid_q;
    assign busy         = (state_q != IDLE) || !fifo_empty;

    // Next-state and handshake decode; tx_done/rx_valid are ignored while idle.
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        fifo_pop   = 1'b0;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    fifo_pop   = 1'b1;
                    tx_data_d  = fifo_dout;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (spi.tx_done) begin
                    tx_valid_d = 1'b0;
                    if (spi.rx_valid) begin
                        capture = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_RX;
                    end
                end else if (spi.rx_valid) begin
                    capture = 1'b1;
                end
            end
            WAIT_RX: begin
                tx_valid_d = 1'b0;
                if (spi.rx_valid) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // State, TX presentation register and dropped-write pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            overflow   <= wr_en && full && !fifo_pop;
        end
    end

    // Received-byte slot: a capture wins over a same-cycle handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_out_valid <= 1'b0;
            rx_out_data  <= '0;
        end else if (capture) begin
            rx_out_valid <= 1'b1;
            rx_out_data  <= spi.rx_data;
        end else if (rx_out_valid && rx_out_ready) begin
            rx_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// tb/tb_spi_xfer_queue.sv - self-checking bench for spi_xfer_queue
module tb_spi_xfer_queue;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          busy;
    logic [DW-1:0] rx_out_data;
    logic          rx_out_valid;
    logic          rx_out_ready;

    spi_xfer_queue_if #(.DATA_W(DW)) bus ();

    spi_xfer_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .level        (level),
        .overflow     (overflow),
        .busy         (busy),
        .spi          (bus),
        .rx_out_data  (rx_out_data),
        .rx_out_valid (rx_out_valid),
        .rx_out_ready (rx_out_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       wr;  logic [7:0] wd;
        logic       dn;  logic       rv;  logic [7:0] rd;  logic rdy;
        logic       etv; logic [7:0] etd; logic [2:0] elv; logic efl;
        logic       eov; logic       erv; logic [7:0] erd; logic ebs;
    } vec_t;
    vec_t vt[$];

    function automatic void add(logic wr, logic [7:0] wd, logic dn, logic rv, logic [7:0] rd,
                                logic rdy, logic etv, logic [7:0] etd, logic [2:0] elv,
                                logic efl, logic eov, logic erv, logic [7:0] erd, logic ebs);
        vt.push_back('{wr, wd, dn, rv, rd, rdy, etv, etd, elv, efl, eov, erv, erd, ebs});
    endfunction

    // Reference model: bytes written but not yet started, responses owed to the consumer.
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         accepted, starts;
    logic       prev_txv;
    bit         m_act;
    int         m_cnt, rx_wait;
    logic [7:0] m_byte;
    int         byte_time, rx_lag, rdy_mode;
    bit         rand_timing;

    function automatic logic [7:0] resp(input logic [7:0] b);
        return {b[3:0], b[7:4]} ^ 8'h3C;
    endfunction

    task automatic clear_model();
        tx_exp.delete(); rx_exp.delete();
        accepted = 0; starts = 0; prev_txv = 1'b0;
        m_act = 1'b0; m_cnt = 0; rx_wait = 0;
        m_byte = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0; wr_en = 1'b0; wr_data = '0; rx_out_ready = 1'b0;
        bus.tx_done = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // One clock of model-driven traffic; called and returns at posedge+1.
    task automatic cycle(input bit we, input logic [7:0] wd);
        int lag;
        wr_en = we; wr_data = wd;
        rx_out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        if (we) begin tx_exp.push_back(wd); accepted++; end
        if (rx_out_valid && rx_out_ready) begin
            if (rx_exp.size() == 0) chk("rx_extra", 1, 0);
            else chk("rx_order", rx_out_data, rx_exp.pop_front());
        end
        @(posedge clk); #1;
        wr_en = 1'b0; bus.tx_done = 1'b0; bus.rx_valid = 1'b0;
        if (bus.tx_valid && !prev_txv) begin
            starts++;
            if (tx_exp.size() == 0) chk("tx_extra", 1, 0);
            else begin
                m_byte = tx_exp.pop_front();
                chk("tx_order", bus.tx_data, m_byte);
            end
            rx_exp.push_back(resp(m_byte));
            m_act = 1'b1;
            m_cnt = rand_timing ? int'($urandom_range(0, 3)) : byte_time;
        end
        prev_txv = bus.tx_valid;
        chk("level", level, accepted - starts);
        chk("no_overflow", overflow, 0);
        if (m_act && bus.tx_valid) begin
            if (m_cnt == 0) begin
                bus.tx_done = 1'b1;
                m_act = 1'b0;
                lag = rand_timing ? int'($urandom_range(0, 2)) : rx_lag;
                if (lag == 0) begin
                    bus.rx_valid = 1'b1; bus.rx_data = resp(m_byte);
                end else rx_wait = lag;
            end else m_cnt--;
        end else if (rx_wait > 0) begin
            rx_wait--;
            if (rx_wait == 0) begin
                bus.rx_valid = 1'b1; bus.rx_data = resp(m_byte);
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && (tx_exp.size() != 0 || rx_exp.size() != 0 || m_act || rx_wait != 0); k++)
            cycle(1'b0, 8'h00);
        chk("drain_left", tx_exp.size() + rx_exp.size(), 0);
    endtask

    initial begin
        rand_timing = 1'b0; byte_time = 0; rx_lag = 0; rdy_mode = 1;
        do_reset();

        // Reset state
        chk("rst_txv", bus.tx_valid, 0);
        chk("rst_txd", bus.tx_data, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_rov", rx_out_valid, 0);
        chk("rst_rod", rx_out_data, 0);
        chk("rst_busy", busy, 0);

        //   wr  wd     dn rv rd     rdy | txv txd   lvl fl ov rov rod   busy
        add(0, 8'h00, 1, 1, 8'h99, 0,   0, 8'h00, 0, 0, 0, 0, 8'h00, 0); // idle pulses ignored
        add(1, 8'hA5, 0, 0, 8'h00, 1,   0, 8'h00, 1, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 8'h00, 1,   1, 8'hA5, 0, 0, 0, 0, 8'h00, 1); // 2 cycles after write
        add(0, 8'h00, 1, 1, 8'h3C, 1,   0, 8'hA5, 0, 0, 0, 1, 8'h3C, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0,   0, 8'hA5, 0, 0, 0, 1, 8'h3C, 0); // slot held
        add(1, 8'h11, 0, 0, 8'h00, 0,   0, 8'hA5, 1, 0, 0, 1, 8'h3C, 1);
        add(1, 8'h22, 0, 0, 8'h00, 0,   0, 8'hA5, 2, 0, 0, 1, 8'h3C, 1);
        add(1, 8'h33, 0, 0, 8'h00, 0,   0, 8'hA5, 3, 0, 0, 1, 8'h3C, 1);
        add(1, 8'h44, 0, 0, 8'h00, 0,   0, 8'hA5, 4, 1, 0, 1, 8'h3C, 1);
        add(1, 8'h55, 0, 0, 8'h00, 0,   0, 8'hA5, 4, 1, 1, 1, 8'h3C, 1); // dropped write
        add(0, 8'h00, 0, 0, 8'h00, 0,   0, 8'hA5, 4, 1, 0, 1, 8'h3C, 1);
        add(0, 8'h00, 0, 0, 8'h00, 1,   1, 8'h11, 3, 0, 0, 0, 8'h3C, 1); // handshake frees slot
        add(0, 8'h00, 0, 0, 8'h00, 1,   1, 8'h11, 3, 0, 0, 0, 8'h3C, 1);
        add(0, 8'h00, 1, 0, 8'h00, 1,   0, 8'h11, 3, 0, 0, 0, 8'h3C, 1); // split: done at N
        add(0, 8'h00, 0, 0, 8'h00, 1,   0, 8'h11, 3, 0, 0, 0, 8'h3C, 1);
        add(0, 8'h00, 0, 0, 8'h00, 1,   0, 8'h11, 3, 0, 0, 0, 8'h3C, 1);
        add(0, 8'h00, 0, 1, 8'hEE, 1,   0, 8'h11, 3, 0, 0, 1, 8'hEE, 1); // rx at N+3
        add(0, 8'h00, 0, 0, 8'h00, 1,   1, 8'h22, 2, 0, 0, 0, 8'hEE, 1);

        for (int i = 0; i < vt.size(); i++) begin
            wr_en = vt[i].wr; wr_data = vt[i].wd;
            bus.tx_done = vt[i].dn; bus.rx_valid = vt[i].rv; bus.rx_data = vt[i].rd;
            rx_out_ready = vt[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("v%0d txv", i), bus.tx_valid, vt[i].etv);
            chk($sformatf("v%0d txd", i), bus.tx_data, vt[i].etd);
            chk($sformatf("v%0d level", i), level, vt[i].elv);
            chk($sformatf("v%0d full", i), full, vt[i].efl);
            chk($sformatf("v%0d ovf", i), overflow, vt[i].eov);
            chk($sformatf("v%0d rov", i), rx_out_valid, vt[i].erv);
            chk($sformatf("v%0d rod", i), rx_out_data, vt[i].erd);
            chk($sformatf("v%0d busy", i), busy, vt[i].ebs);
        end

        // Reset mid-transfer: SEND in progress with two bytes queued
        wr_en = 1'b0; bus.tx_done = 1'b0; bus.rx_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("arst_txv", bus.tx_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_rov", rx_out_valid, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1 rstn = 1'b1;
        wr_en = 1'b1; wr_data = 8'h77; rx_out_ready = 1'b1;
        @(posedge clk); #1 wr_en = 1'b0;
        chk("post_rst_lvl", level, 1);
        chk("post_rst_txv0", bus.tx_valid, 0);
        @(posedge clk); #1;
        chk("post_rst_txv", bus.tx_valid, 1);
        chk("post_rst_txd", bus.tx_data, 8'h77);
        bus.tx_done = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h88;
        @(posedge clk); #1 bus.tx_done = 1'b0; bus.rx_valid = 1'b0;
        chk("post_rst_rov", rx_out_valid, 1);
        chk("post_rst_rod", rx_out_data, 8'h88);

        // Wrap-around: ten single-byte transfers
        do_reset();
        rdy_mode = 1; byte_time = 1; rx_lag = 0;
        for (int b = 8'h10; b <= 8'h19; b++) begin
            cycle(1'b1, 8'(b));
            drain();
        end
        chk("wrap_starts", starts, 10);

        // Burst with back-pressure
        do_reset();
        rdy_mode = 0; byte_time = 2; rx_lag = 1;
        for (int b = 1; b <= 4; b++) cycle(1'b1, 8'(b));
        repeat (15) cycle(1'b0, 8'h00);
        chk("bp_starts", starts, 1);
        chk("bp_txv", bus.tx_valid, 0);
        chk("bp_level", level, 3);
        chk("bp_rov", rx_out_valid, 1);
        rdy_mode = 1;
        drain();
        chk("bp_all_sent", starts, 4);

        // Randomized traffic against the model
        do_reset();
        rand_timing = 1'b1; rdy_mode = 2;
        for (int k = 0; k < 400; k++)
            cycle(($urandom_range(0, 1) == 1) && (accepted - starts < DEPTH), 8'($urandom));
        drain();
        chk("rand_all_sent", starts, accepted);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
